adv_init_sequencer: RTL and testbench
=====================================

# adv_init_sequencer

Register-programming sequencer that sits directly upstream of the I2C subsystem driving the ADV7513 serial port. After reset, on a start request or on a hot-plug rising edge, it walks a fixed table of ADV7513 register writes and issues each one to the I2C master through a request/done handshake. It retries NACKed writes and reports configured/error status to the top level. Video output is gated by that status.

## Interface
- `DEV_ADDR`, default 7'h39: 7-bit ADV7513 main-map I2C address, presented on `DevAddr`.
- `STARTUP_WAIT`, default 2048: `Clock` cycles to wait before the first write of every run, for ADV7513 power-up settle.
- `RETRY_LIMIT`, default 3: retries allowed per entry after a NACK. Total attempts per entry = `RETRY_LIMIT`+1.
- `RETRY_GAP`, default 64: idle `Clock` cycles between a NACKed attempt and its retry.
- `Clock` in 1: single clock, the I2C subsystem clock.
- `Reset_n` in 1: synchronous, active-low reset.
- `Go` in 1: start request. Rising edge starts a run.
- `HPD` in 1: hot-plug detect level, already synchronised to `Clock`. Rising edge starts a run.
- `Req` out 1: one-cycle write request to the I2C master.
- `DevAddr` out 7: I2C device address, constant `DEV_ADDR`.
- `RegAddr` out 8: register address of the current entry.
- `RegData` out 8: register data of the current entry.
- `Busy` in 1: I2C master transaction in progress.
- `Done` in 1: one-cycle pulse at the end of a transaction.
- `Nack` in 1: valid only with `Done`. 1 means the slave did not acknowledge.
- `Active` out 1: a run is in progress.
- `Configured` out 1: the last run completed all entries.
- `Error` out 1: the last run aborted on retry exhaustion.
- `ErrIndex` out 4: table index of the failed entry. Valid while `Error`=1.

## Operation
- Table: 12 fixed entries, index 0..11, as {addr, data}. Entries in order: 41/10, 98/03, 9A/E0, 9C/30, 9D/61, A2/A4, A3/A4, E0/D0, F9/00, 15/00, 16/30, 18/46.
- States:
  - IDLE: waiting for a trigger.
  - WAIT: counting `STARTUP_WAIT` cycles.
  - ISSUE: waiting to issue the current entry.
  - XFER: waiting for `Done`.
  - GAP: counting `RETRY_GAP` cycles before a retry.
  - DONE: run complete.
  - FAIL: run aborted.
- Trigger = rising edge of `Go` or of `HPD`. Edge detection uses registered previous values, which reset to 0.
- A trigger in IDLE, DONE or FAIL:
  - enters WAIT,
  - clears index, retry count, `Configured` and `Error`,
  - sets `Active`.
- Triggers in WAIT, ISSUE, XFER or GAP are ignored.
- `HPD` falling edge in any state:
  - abort to IDLE,
  - clear `Active` and `Configured`,
  - `Error` unchanged.
  - If a transaction is in flight, the sequencer does not wait for its `Done`. Any late `Done` in IDLE is ignored.
- WAIT → ISSUE when the counter reaches `STARTUP_WAIT`-1.
- ISSUE: if `Busy`=0, pulse `Req` for one cycle and go to XFER. If `Busy`=1, stay in ISSUE with no `Req`.
- `RegAddr`/`RegData` reflect the current entry from ISSUE entry until the next index change. They are stable for the whole transaction.
- XFER on `Done`=1:
  - `Nack`=0: reset retry count, increment index. Index 11 → DONE; otherwise → ISSUE.
  - `Nack`=1 and retry count < `RETRY_LIMIT`: increment retry count, go to GAP.
  - `Nack`=1 otherwise: latch index into `ErrIndex`, go to FAIL.
- GAP → ISSUE after `RETRY_GAP` cycles. The index is unchanged.
- DONE: `Configured`=1, `Active`=0.
- FAIL: `Error`=1, `Active`=0.
- No timeout on `Done`. The I2C master guarantees a `Done` for every accepted `Req`.

## Timing
- Reset values:
  - state IDLE,
  - `Req`=0, `Active`=0, `Configured`=0, `Error`=0, `ErrIndex`=0,
  - `RegAddr`=8'h41, `RegData`=8'h10 (entry 0),
  - `DevAddr`=`DEV_ADDR`.
- Reset asserted mid-run returns to IDLE on the next edge. No `Req` is issued while `Reset_n`=0.
- Trigger sampled at edge t → `Active`=1 from t+1.
- First `Req` at t+1+`STARTUP_WAIT`, provided `Busy`=0.
- `Req` is never asserted in two consecutive cycles.
- `Done` at edge d:
  - success → the next `Req` no earlier than d+2;
  - NACK → retry `Req` no earlier than d+1+`RETRY_GAP`.
- `Configured`/`Error` rise the cycle after the final `Done`. They hold until the next trigger, an `HPD` fall (`Configured` only) or reset.
- All outputs registered. No combinational path from inputs to outputs.

## Test plan
- Reset, then `Go` pulse; I2C model always ACKs with 20-cycle transactions → 12 `Req` pulses carrying 41/10 … 18/46 in order; first `Req` `STARTUP_WAIT`+1 cycles after the trigger; `Configured`=1, `Active`=0, `Error`=0.
- NACK on entry 4 (9D) twice, then ACK → 9D/61 issued 3 times, consecutive attempts ≥`RETRY_GAP`+1 cycles apart; run completes with `Configured`=1.
- Entry 7 always NACKs → exactly 4 attempts at E0/D0; `Error`=1, `ErrIndex`=7, `Configured`=0; no further `Req`.
- `Busy` held high 50 cycles when entering ISSUE → no `Req` until the cycle after `Busy` falls.
- `HPD` falls during XFER of entry 3, then late `Done` → IDLE, `Active`=0, no `Req`; `HPD` rise → fresh run restarts at entry 0 after `STARTUP_WAIT`.
- `Go` pulse mid-run, and `Reset_n` low mid-run → `Go` ignored (sequence uninterrupted); reset gives all outputs at reset values and no `Req` until the next trigger.

Source files
------------

// File: rtl/adv_init_sequencer.sv
// adv_init_sequencer: walks a fixed ADV7513 register table through an I2C master, with retry and status reporting
module adv_init_sequencer #(
    parameter logic [6:0] DEV_ADDR     = 7'h39,
    parameter int          STARTUP_WAIT = 2048,
    parameter int          RETRY_LIMIT  = 3,
    parameter int          RETRY_GAP    = 64
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Go,
    input  logic       HPD,
    output logic       Req,
    output logic [6:0] DevAddr,
    output logic [7:0] RegAddr,
    output logic [7:0] RegData,
    input  logic       Busy,
    input  logic       Done,
    input  logic       Nack,
    output logic       Active,
    output logic       Configured,
    output logic       Error,
    output logic [3:0] ErrIndex
);
    localparam int CNT_MAX = (STARTUP_WAIT > RETRY_GAP) ? STARTUP_WAIT : RETRY_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = $clog2(RETRY_LIMIT + 2);
    localparam logic [15:0] TABLE [12] = '{
        16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
        16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'h1846
    };

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_XFER, S_GAP, S_DONE, S_FAIL} state_t;

    state_t             state;
    logic               go_q;
    logic               hpd_q;
    logic [3:0]         idx;
    logic [RTY_W-1:0]   retry;
    logic [CNT_W-1:0]   cnt;
    logic               trigger;
    logic               hpd_fall;
    logic               can_start;

    assign DevAddr   = DEV_ADDR;
    assign trigger   = (Go & ~go_q) | (HPD & ~hpd_q);
    assign hpd_fall  = hpd_q & ~HPD;
    assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_FAIL);

    // Sequencer FSM; an HPD fall outranks everything, a trigger only starts a run from a resting state
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            go_q       <= 1'b0;
            hpd_q      <= 1'b0;
            idx        <= '0;
            retry      <= '0;
            cnt        <= '0;
            Req        <= 1'b0;
            Active     <= 1'b0;
            Configured <= 1'b0;
            Error      <= 1'b0;
            ErrIndex   <= '0;
            RegAddr    <= TABLE[0][15:8];
            RegData    <= TABLE[0][7:0];
        end else begin
            go_q  <= Go;
            hpd_q <= HPD;
            Req   <= 1'b0;
            if (hpd_fall) begin
                state      <= S_IDLE;
                Active     <= 1'b0;
                Configured <= 1'b0;
            end else if (trigger && can_start) begin
                state              <= S_WAIT;
                idx                <= '0;
                {RegAddr, RegData} <= TABLE[0];
                retry              <= '0;
                // the trigger cycle is the first settle cycle, so the first Req lands STARTUP_WAIT+1 cycles after the trigger
                cnt                <= CNT_W'(1);
                Configured         <= 1'b0;
                Error              <= 1'b0;
                Active             <= 1'b1;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (cnt >= CNT_W'(STARTUP_WAIT - 1)) state <= S_ISSUE;
                        else cnt <= cnt + CNT_W'(1);
                    end
                    S_ISSUE: begin
                        if (!Busy) begin
                            Req   <= 1'b1;
                            state <= S_XFER;
                        end
                    end
                    S_XFER: begin
                        if (Done) begin
                            if (!Nack) begin
                                retry <= '0;
                                if (idx == 4'd11) begin
                                    state      <= S_DONE;
                                    Configured <= 1'b1;
                                    Active     <= 1'b0;
                                end else begin
                                    idx                <= idx + 4'd1;
                                    {RegAddr, RegData} <= TABLE[idx + 4'd1];
                                    state              <= S_ISSUE;
                                end
                            end else if (retry < RTY_W'(RETRY_LIMIT)) begin
                                retry <= retry + RTY_W'(1);
                                cnt   <= '0;
                                state <= S_GAP;
                            end else begin
                                ErrIndex <= idx;
                                Error    <= 1'b1;
                                Active   <= 1'b0;
                                state    <= S_FAIL;
                            end
                        end
                    end
                    S_GAP: begin
                        if (cnt >= CNT_W'(RETRY_GAP - 1)) state <= S_ISSUE;
                        else cnt <= cnt + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adv_init_sequencer.sv
// tb_adv_init_sequencer: table-driven runs against an I2C master model, with a scoreboard of expected writes
module tb_adv_init_sequencer;
    localparam int SW  = 16;
    localparam int RL  = 3;
    localparam int RG  = 8;
    localparam int LAT = 20;
    localparam logic [15:0] TBL [12] = '{
        16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4,
        16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'h1846
    };

    typedef struct {
        int         ne;
        int         nc;
        int         be;
        logic       cfg;
        logic       err;
        logic [3:0] eidx;
    } vec_t;

    logic       clk = 1'b0;
    logic       Reset_n, Go, HPD, Req, Busy, Done, Nack, Active, Configured, Error;
    logic [6:0] DevAddr;
    logic [7:0] RegAddr, RegData;
    logic [3:0] ErrIndex;

    logic [15:0] exp_q [$];
    vec_t        vecs [6];
    int          errors = 0, checks = 0, cyc = 0;
    int          lat_cnt = 0, busy_hold = 0, nack_entry = -1, nack_count = 0, attempts = 0, busy_entry = -1;
    int          req_count = 0, busy_fall_cyc = 0, last_req_cyc = 0, trig_cyc = 0, base = 0;
    bit          in_xfer = 0, cur_nack = 0, busy_pending = 0, check_first = 0, req_prev = 0;
    logic [7:0]  last_addr = 8'h00;

    always #5 clk = ~clk;

    adv_init_sequencer #(.DEV_ADDR(7'h39), .STARTUP_WAIT(SW), .RETRY_LIMIT(RL), .RETRY_GAP(RG)) dut (
        .Clock(clk), .Reset_n(Reset_n), .Go(Go), .HPD(HPD), .Req(Req), .DevAddr(DevAddr),
        .RegAddr(RegAddr), .RegData(RegData), .Busy(Busy), .Done(Done), .Nack(Nack),
        .Active(Active), .Configured(Configured), .Error(Error), .ErrIndex(ErrIndex)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // one cycle: observe DUT outputs at the falling edge, then advance the I2C master model
    task automatic tick();
        logic [15:0] e;
        @(negedge clk);
        cyc++;
        if (Req) begin
            req_count++;
            chk("req_not_back_to_back", 32'(req_prev), 32'd0);
            chk("req_while_busy", 32'(Busy), 32'd0);
            chk("dev_addr", 32'(DevAddr), 32'h39);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got %h/%h, required no Req (cycle %0d)", RegAddr, RegData, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("req_entry", 32'({RegAddr, RegData}), 32'(e));
            end
            if (check_first) begin
                chk("first_req_latency", 32'(cyc - trig_cyc), 32'(SW + 1));
                check_first = 0;
            end
            if (busy_pending) begin
                chk("req_after_busy_fall", 32'(cyc - busy_fall_cyc), 32'd1);
                busy_pending = 0;
            end
            if (RegAddr == last_addr) chk("retry_spacing", 32'(cyc - last_req_cyc >= RG + 1), 32'd1);
            last_addr    = RegAddr;
            last_req_cyc = cyc;
        end
        req_prev = Req;
        Done = 1'b0;
        Nack = 1'b0;
        if (in_xfer) begin
            if (lat_cnt == 0) begin
                in_xfer = 0;
                Done    = 1'b1;
                Nack    = cur_nack;
                Busy    = 1'b0;
                if (!cur_nack && busy_entry >= 0 && last_addr == TBL[busy_entry][15:8]) begin
                    busy_hold = 50;
                    Busy      = 1'b1;
                end
            end else lat_cnt--;
        end else if (busy_hold > 0) begin
            busy_hold--;
            if (busy_hold == 0) begin
                Busy          = 1'b0;
                busy_fall_cyc = cyc;
                busy_pending  = 1;
            end
        end
        if (Req) begin
            in_xfer  = 1;
            lat_cnt  = LAT;
            Busy     = 1'b1;
            cur_nack = 0;
            if (nack_entry >= 0 && RegAddr == TBL[nack_entry][15:8]) begin
                cur_nack = (attempts < nack_count);
                attempts++;
            end
        end
    endtask

    task automatic push_entries(input int first, input int last);
        for (int i = first; i <= last; i++) exp_q.push_back(TBL[i]);
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (Active && k < bound) begin
            tick();
            k++;
        end
        chk("run_terminates", 32'(Active), 32'd0);
    endtask

    task automatic wait_reqs(input int n, input int bound);
        int k = 0;
        while (req_count < n && k < bound) begin
            tick();
            k++;
        end
        chk("req_count_reached", 32'(req_count >= n), 32'd1);
    endtask

    task automatic pulse_go(input bit first_check);
        Go          = 1'b1;
        trig_cyc    = cyc;
        check_first = first_check;
        tick();
        Go = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(Req), 32'd0);
        chk({tag, "_active"}, 32'(Active), 32'd0);
        chk({tag, "_configured"}, 32'(Configured), 32'd0);
        chk({tag, "_error"}, 32'(Error), 32'd0);
        chk({tag, "_errindex"}, 32'(ErrIndex), 32'd0);
        chk({tag, "_regaddr"}, 32'(RegAddr), 32'h41);
        chk({tag, "_regdata"}, 32'(RegData), 32'h10);
        chk({tag, "_devaddr"}, 32'(DevAddr), 32'h39);
    endtask

    initial begin
        Reset_n = 1'b0;
        Go      = 1'b0;
        HPD     = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        Nack    = 1'b0;
        vecs[0] = '{-1, 0, -1, 1'b1, 1'b0, 4'd0};
        vecs[1] = '{4, 2, -1, 1'b1, 1'b0, 4'd0};
        vecs[2] = '{7, 100, -1, 1'b0, 1'b1, 4'd7};
        vecs[3] = '{0, 3, -1, 1'b1, 1'b0, 4'd0};
        vecs[4] = '{11, 4, -1, 1'b0, 1'b1, 4'd11};
        vecs[5] = '{-1, 0, 2, 1'b1, 1'b0, 4'd0};
        repeat (3) tick();
        chk_reset_outputs("reset");
        Reset_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            nack_entry = vecs[v].ne;
            nack_count = vecs[v].nc;
            busy_entry = vecs[v].be;
            attempts   = 0;
            for (int i = 0; i < 12; i++) begin
                int n;
                n = (i == vecs[v].ne) ? ((vecs[v].nc > RL) ? RL + 1 : vecs[v].nc + 1) : 1;
                for (int j = 0; j < n; j++) exp_q.push_back(TBL[i]);
                if (i == vecs[v].ne && vecs[v].nc > RL) break;
            end
            pulse_go(1);
            chk("active_after_trigger", 32'(Active), 32'd1);
            chk("configured_cleared", 32'(Configured), 32'd0);
            chk("error_cleared", 32'(Error), 32'd0);
            wait_idle(4000);
            chk("final_configured", 32'(Configured), 32'(vecs[v].cfg));
            chk("final_error", 32'(Error), 32'(vecs[v].err));
            if (vecs[v].err) chk("final_errindex", 32'(ErrIndex), 32'(vecs[v].eidx));
            repeat (40) tick();
            chk("all_reqs_seen", 32'(exp_q.size()), 32'd0);
        end
        nack_entry = -1;
        busy_entry = -1;

        push_entries(0, 3);
        base        = req_count;
        HPD         = 1'b1;
        trig_cyc    = cyc;
        check_first = 1;
        tick();
        chk("hpd_rise_active", 32'(Active), 32'd1);
        wait_reqs(base + 4, 2000);
        repeat (3) tick();
        HPD = 1'b0;
        tick();
        chk("hpd_fall_active", 32'(Active), 32'd0);
        chk("hpd_fall_configured", 32'(Configured), 32'd0);
        repeat (60) tick();
        chk("hpd_abort_stays_idle", 32'(Active), 32'd0);
        push_entries(0, 11);
        HPD         = 1'b1;
        trig_cyc    = cyc;
        check_first = 1;
        tick();
        chk("hpd_restart_active", 32'(Active), 32'd1);
        wait_idle(4000);
        chk("hpd_restart_configured", 32'(Configured), 32'd1);
        chk("hpd_restart_all_seen", 32'(exp_q.size()), 32'd0);

        push_entries(0, 11);
        base = req_count;
        pulse_go(1);
        chk("go_run_active", 32'(Active), 32'd1);
        wait_reqs(base + 5, 2000);
        pulse_go(0);
        wait_idle(4000);
        chk("go_midrun_configured", 32'(Configured), 32'd1);
        chk("go_midrun_all_seen", 32'(exp_q.size()), 32'd0);
        HPD = 1'b0;
        tick();
        chk("hpd_fall_clears_configured", 32'(Configured), 32'd0);

        push_entries(0, 2);
        base = req_count;
        pulse_go(1);
        wait_reqs(base + 3, 2000);
        repeat (2) tick();
        Reset_n = 1'b0;
        tick();
        chk_reset_outputs("midrun_reset");
        repeat (4) tick();
        Reset_n = 1'b1;
        repeat (60) tick();
        chk_reset_outputs("post_reset");
        chk("reset_run_all_seen", 32'(exp_q.size()), 32'd0);
        push_entries(0, 11);
        pulse_go(1);
        wait_idle(4000);
        chk("after_reset_configured", 32'(Configured), 32'd1);
        chk("after_reset_all_seen", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
